spi_cfg_seq: RTL and testbench

SPI_CFG_SEQ -- requirements
Module: spi_cfg_seq

---
 rtl/spi_cfg_seq_pkg.sv | 14 +
 rtl/cfg_fifo.sv | 75 +++++++
 rtl/spi_cfg_defs.vh | 20 ++
 rtl/spi_cfg_seq.sv | 157 +++++++++++++++
 tb/tb_spi_cfg_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cfg_seq_pkg.sv
// rtl/spi_cfg_seq_pkg.sv - shared types, constants and helpers for spi_cfg_seq
// Purpose: wraps the shared definitions and adds a sizing helper.
// Ports:   none (package).
package spi_cfg_seq_pkg;

`include "spi_cfg_defs.vh"

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cfg_fifo.sv
// rtl/cfg_fifo.sv - word buffer with level counter for the SPI config sequencer
// Purpose: FIFO-ordered storage; pointers wrap modulo DEPTH, occupancy and full
//          come from a registered level counter.
// Ports:   clk, rst (async, active high); push/din write; pop/dout read
//          (dout shows the head word combinationally); flush empties the buffer;
//          level = occupancy, full = level==DEPTH (both registered).
module cfg_fifo
   import spi_cfg_seq_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int DEPTH     = 16
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [DATAWIDTH-1:0]       din,
   output logic [DATAWIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]        wptr;
   logic [AW-1:0]        rptr;
   logic [LW-1:0]        level_d;
   logic                 do_push;
   logic                 do_pop;

   // When full, a push is only accepted alongside a pop: the write lands in
   // the slot being vacated, which is read out before the edge.
   assign do_pop  = pop && (level != '0);
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr];

   always_comb begin
      level_d = level;
      if (flush) begin
         level_d = '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   level_d = level + 1'b1;
            2'b01:   level_d = level - 1'b1;
            default: level_d = level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         full  <= 1'b0;
      end else begin
         level <= level_d;
         full  <= (level_d == LW'(DEPTH));
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr] <= din;
   end

endmodule

// File: rtl/spi_cfg_defs.vh
// rtl/spi_cfg_defs.vh - sequencer state encodings and default timing constants
// Purpose: shared definitions for the SPI configuration sequencer, pulled into
//          spi_cfg_seq_pkg so every file sees a single copy.
// Ports:   none (definitions only).
`ifndef SPI_CFG_DEFS_VH
`define SPI_CFG_DEFS_VH

typedef enum logic [2:0] {
   ST_IDLE  = 3'd0,
   ST_SETUP = 3'd1,
   ST_XFER  = 3'd2,
   ST_GAP   = 3'd3,
   ST_DONE  = 3'd4
} state_t;

localparam int DEF_SETUP_CYC = 2;
localparam int DEF_GAP_CYC   = 8;
localparam int DEF_TIMEOUT   = 4096;

`endif

// File: rtl/spi_cfg_seq.sv
// rtl/spi_cfg_seq.sv - drains buffered config words through an SPI master
// Purpose: buffers words, then on go sends each one framed by chip select:
//          SETUP (cs low, master in reset), XFER (master enabled until finished
//          or timeout), GAP (cs high), ending with a one-cycle done pulse.
// Ports:   clk, rst (async, active high); wr_en/wr_data push; go start;
//          spi_finished from master; spi_din/spi_en/spi_rst to master; cs_n to
//          slave; busy, done, full, level, ovf, tmo status (all registered).
module spi_cfg_seq
   import spi_cfg_seq_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int DEPTH     = 16,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int GAP_CYC   = DEF_GAP_CYC,
   parameter int TIMEOUT   = DEF_TIMEOUT
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATAWIDTH-1:0]    wr_data,
   input  logic                    go,
   input  logic                    spi_finished,
   output logic [DATAWIDTH-1:0]    spi_din,
   output logic                    spi_en,
   output logic                    spi_rst,
   output logic                    cs_n,
   output logic                    busy,
   output logic                    done,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf,
   output logic                    tmo
);
   localparam int CW = $clog2(max3(SETUP_CYC, GAP_CYC, TIMEOUT)) + 1;

   state_t                state, nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [DATAWIDTH-1:0]  fifo_dout;
   logic                  pop, load_din, clr_flags, set_tmo, flush;

   cfg_fifo #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (pop),
      .flush (flush),
      .din   (wr_data),
      .dout  (fifo_dout),
      .level (level),
      .full  (full)
   );

   // One down-counter serves SETUP, XFER timeout and GAP; it is reloaded with
   // the duration minus one on entry to each state and the state exits at 0.
   always_comb begin
      nxt       = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      load_din  = 1'b0;
      clr_flags = 1'b0;
      set_tmo   = 1'b0;
      flush     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (go) begin
               if (level != '0) begin
                  pop       = 1'b1;
                  load_din  = 1'b1;
                  clr_flags = 1'b1;
                  nxt       = ST_SETUP;
                  cnt_nxt   = CW'(SETUP_CYC - 1);
               end else begin
                  nxt = ST_DONE;
               end
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               nxt     = ST_XFER;
               cnt_nxt = CW'(TIMEOUT - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_XFER: begin
            if (spi_finished) begin
               nxt     = ST_GAP;
               cnt_nxt = CW'(GAP_CYC - 1);
            end else if (cnt == '0) begin
               nxt     = ST_GAP;
               cnt_nxt = CW'(GAP_CYC - 1);
               set_tmo = 1'b1;
               flush   = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               // After a timeout the drain ends even if words arrived during GAP.
               if (level != '0 && !tmo) begin
                  pop      = 1'b1;
                  load_din = 1'b1;
                  nxt      = ST_SETUP;
                  cnt_nxt  = CW'(SETUP_CYC - 1);
               end else begin
                  nxt = ST_DONE;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_DONE: begin
            nxt = ST_IDLE;
         end
         default: begin
            nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so pins change on the same
   // edge as the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         spi_din <= '0;
         cs_n    <= 1'b1;
         spi_en  <= 1'b0;
         spi_rst <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         tmo     <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= cnt_nxt;
         if (load_din) spi_din <= fifo_dout;
         cs_n    <= !((nxt == ST_SETUP) || (nxt == ST_XFER));
         spi_en  <= (nxt == ST_XFER);
         spi_rst <= (nxt != ST_XFER);
         busy    <= (nxt != ST_IDLE);
         done    <= (nxt == ST_DONE);
         if (clr_flags) begin
            ovf <= 1'b0;
            tmo <= 1'b0;
         end
         if (wr_en && full && !pop) ovf <= 1'b1;
         if (set_tmo) tmo <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_cfg_seq.sv
// tb/tb_spi_cfg_seq.sv - directed self-checking bench for spi_cfg_seq
module tb_spi_cfg_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        go = 1'b0;
   logic        spi_finished = 1'b0;
   logic [31:0] spi_din;
   logic        spi_en, spi_rst, cs_n, busy, done, full, ovf, tmo;
   logic [2:0]  level;

   int n_cmp = 0;
   int n_err = 0;

   spi_cfg_seq #(
      .DATAWIDTH (32), .DEPTH (4), .SETUP_CYC (2), .GAP_CYC (4), .TIMEOUT (64)
   ) dut (
      .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .go (go),
      .spi_finished (spi_finished), .spi_din (spi_din), .spi_en (spi_en),
      .spi_rst (spi_rst), .cs_n (cs_n), .busy (busy), .done (done),
      .full (full), .level (level), .ovf (ovf), .tmo (tmo)
   );

   always #5 clk = ~clk;

   // SPI master model: sticky finished 40 cycles after spi_en rises.
   bit master_on = 1'b1;
   int m_cnt = 0;
   always @(negedge clk) begin
      if (rst || spi_rst) begin
         m_cnt = 0;
         spi_finished = 1'b0;
      end else if (spi_en && master_on) begin
         m_cnt++;
         if (m_cnt >= 40) spi_finished = 1'b1;
      end
   end

   // Bus monitor: words sent, enable lengths, cs_n-high gaps, done pulses.
   logic [31:0] words [$];
   int          en_lens [$];
   int          gaps [$];
   int          done_cnt = 0, cs_falls = 0, din_bad = 0, en_run = 0, gap_run = 0;
   bit          gap_armed = 1'b0;
   logic        prev_en = 1'b0, prev_cs = 1'b1;
   always @(negedge clk) begin
      if (spi_en && !prev_en) begin words.push_back(spi_din); en_run = 0; end
      if (spi_en) begin
         en_run++;
         if (spi_din !== words[words.size()-1]) din_bad++;
      end
      if (!spi_en && prev_en) en_lens.push_back(en_run);
      if (!cs_n && prev_cs) begin cs_falls++; if (gap_armed) gaps.push_back(gap_run); end
      if (cs_n && !prev_cs) begin gap_run = 0; gap_armed = 1'b1; end
      if (cs_n) gap_run++;
      if (!busy) gap_armed = 1'b0;
      if (done) done_cnt++;
      prev_en = spi_en;
      prev_cs = cs_n;
   end

   // All tasks start and end at a falling edge.
   task automatic push_word(input logic [31:0] w);
      wr_en = 1'b1; wr_data = w;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      int k = 0;
      while (done_cnt == d0 && k < budget) begin @(negedge clk); k++; end
      ok = (done_cnt != d0);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (cs_n !== 1'b1)  begin n_err++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
      n_cmp++; if (spi_en !== 1'b0) begin n_err++; $display("FAIL reset_spi_en got %b want 0", spi_en); end
      n_cmp++; if (spi_rst !== 1'b1) begin n_err++; $display("FAIL reset_spi_rst got %b want 1", spi_rst); end
      n_cmp++; if (spi_din !== 32'h0) begin n_err++; $display("FAIL reset_spi_din got %h want 0", spi_din); end
      n_cmp++; if ({busy, done, full, ovf, tmo} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {busy, done, full, ovf, tmo}); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({cs_n, spi_rst, spi_en, busy} !== 4'b1100) begin n_err++; $display("FAIL post_reset_idle got %b want 1100", {cs_n, spi_rst, spi_en, busy}); end
   endtask

   task automatic test_two_words();
      int w0 = words.size(), l0 = en_lens.size(), g0 = gaps.size(), d0 = done_cnt, b0 = din_bad;
      bit ok;
      push_word(32'h0000_1234);
      push_word(32'hDEAD_BEEF);
      n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL two_level_before got %0d want 2", level); end
      pulse_go();
      wait_done(d0, 400, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL two_done_wait got none want done within 400 cycles"); end
      repeat (4) @(negedge clk);
      n_cmp++; if (words.size() - w0 != 2) begin n_err++; $display("FAIL two_word_count got %0d want 2", words.size() - w0); end
      n_cmp++; if (words[w0] !== 32'h0000_1234) begin n_err++; $display("FAIL two_word0 got %h want 00001234", words[w0]); end
      n_cmp++; if (words[w0+1] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL two_word1 got %h want deadbeef", words[w0+1]); end
      n_cmp++; if (en_lens[l0] != 40 || en_lens[l0+1] != 40) begin n_err++; $display("FAIL two_en_len got %0d,%0d want 40,40", en_lens[l0], en_lens[l0+1]); end
      n_cmp++; if (gaps.size() - g0 != 1 || gaps[g0] != 4) begin n_err++; $display("FAIL two_gap got n=%0d len=%0d want n=1 len=4", gaps.size() - g0, gaps[g0]); end
      n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL two_done_pulses got %0d want 1", done_cnt - d0); end
      n_cmp++; if (level !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL two_end_state got level=%0d busy=%b want 0/0", level, busy); end
      n_cmp++; if (din_bad != b0) begin n_err++; $display("FAIL two_din_stable got %0d changes want 0", din_bad - b0); end
   endtask

   task automatic test_overflow();
      int w0 = words.size(), d0 = done_cnt;
      bit ok;
      logic [31:0] exp [4];
      exp[0] = 32'hA000_0001; exp[1] = 32'hA000_0002; exp[2] = 32'hA000_0003; exp[3] = 32'hA000_0004;
      for (int i = 0; i < 4; i++) push_word(exp[i]);
      push_word(32'hA000_0005);
      n_cmp++; if ({level, full, ovf} !== {3'd4, 1'b1, 1'b1}) begin n_err++; $display("FAIL ovf_status got level=%0d full=%b ovf=%b want 4/1/1", level, full, ovf); end
      pulse_go();
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear_on_go got %b want 0", ovf); end
      wait_done(d0, 700, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_done_wait got none want done within 700 cycles"); end
      repeat (2) @(negedge clk);
      n_cmp++; if (words.size() - w0 != 4) begin n_err++; $display("FAIL ovf_word_count got %0d want 4", words.size() - w0); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (words[w0+i] !== exp[i]) begin n_err++; $display("FAIL ovf_word%0d got %h want %h", i, words[w0+i], exp[i]); end
      end
      n_cmp++; if (level !== 3'd0 || full !== 1'b0) begin n_err++; $display("FAIL ovf_end got level=%0d full=%b want 0/0", level, full); end
   endtask

   task automatic test_empty_go();
      int c0 = cs_falls, d0 = done_cnt;
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL empty_pre_level got %0d want 0", level); end
      pulse_go();
      n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL empty_done_pulse got done=%b busy=%b want 1/1", done, busy); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL empty_back_idle got done=%b busy=%b want 0/0", done, busy); end
      repeat (3) @(negedge clk);
      n_cmp++; if (cs_falls != c0 || cs_n !== 1'b1) begin n_err++; $display("FAIL empty_cs_quiet got falls=%0d cs_n=%b want 0/1", cs_falls - c0, cs_n); end
      n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL empty_done_count got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_timeout();
      int w0 = words.size(), l0 = en_lens.size(), d0 = done_cnt;
      bit ok;
      master_on = 1'b0;
      push_word(32'h5555_0001);
      push_word(32'h5555_0002);
      pulse_go();
      wait_done(d0, 400, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_done_wait got none want done within 400 cycles"); end
      repeat (3) @(negedge clk);
      n_cmp++; if (tmo !== 1'b1) begin n_err++; $display("FAIL tmo_flag got %b want 1", tmo); end
      n_cmp++; if (en_lens[l0] != 64) begin n_err++; $display("FAIL tmo_en_len got %0d want 64", en_lens[l0]); end
      n_cmp++; if (words.size() - w0 != 1 || level !== 3'd0) begin n_err++; $display("FAIL tmo_flush got words=%0d level=%0d want 1/0", words.size() - w0, level); end
      n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL tmo_done_count got %0d want 1", done_cnt - d0); end
      master_on = 1'b1;
   endtask

   task automatic test_push_in_gap();
      int w0 = words.size(), d0 = done_cnt, k = 0;
      bit ok;
      push_word(32'hB000_0001);
      push_word(32'hB000_0002);
      pulse_go();
      n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL gap_tmo_cleared got %b want 0", tmo); end
      while (spi_en !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      k = 0;
      while (cs_n !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      n_cmp++; if (cs_n !== 1'b1 || busy !== 1'b1 || level !== 3'd1) begin n_err++; $display("FAIL gap_reach got cs_n=%b busy=%b level=%0d want 1/1/1", cs_n, busy, level); end
      push_word(32'hB000_0003);
      wait_done(d0, 400, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL gap_done_wait got none want done within 400 cycles"); end
      repeat (3) @(negedge clk);
      n_cmp++; if (words.size() - w0 != 3 || words[w0+1] !== 32'hB000_0002 || words[w0+2] !== 32'hB000_0003) begin
         n_err++; $display("FAIL gap_words got n=%0d w1=%h w2=%h want 3/b0000002/b0000003", words.size() - w0, words[w0+1], words[w0+2]);
      end
      n_cmp++; if (done_cnt - d0 != 1 || level !== 3'd0) begin n_err++; $display("FAIL gap_end got done=%0d level=%0d want 1/0", done_cnt - d0, level); end
   endtask

   task automatic test_reset_mid_xfer();
      int w0 = words.size(), d0 = done_cnt, k = 0;
      push_word(32'hC000_0001);
      push_word(32'hC000_0002);
      push_word(32'hC000_0003);
      pulse_go();
      while (spi_en !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      repeat (9) @(negedge clk);
      n_cmp++; if (spi_en !== 1'b1 || level !== 3'd2) begin n_err++; $display("FAIL rstx_pre got spi_en=%b level=%0d want 1/2", spi_en, level); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({cs_n, spi_en, spi_rst, busy} !== 4'b1010) begin n_err++; $display("FAIL rstx_async_pins got %b want 1010", {cs_n, spi_en, spi_rst, busy}); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rstx_level got %0d want 0", level); end
      @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL rstx_no_done got %0d pulses want 0", done_cnt - d0); end
      n_cmp++; if (words.size() - w0 != 1 || cs_n !== 1'b1) begin n_err++; $display("FAIL rstx_aborted got words=%0d cs_n=%b want 1/1", words.size() - w0, cs_n); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish want finish before 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_two_words();
      test_overflow();
      test_empty_go();
      test_timeout();
      test_push_in_gap();
      test_reset_mid_xfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
